// File: rtl/reset_sequencer.sv
// Domain reset sequencer: holds all domain resets for a minimum time, then releases
// them one by one with a fixed stagger; software requests replay the sequence.
module reset_sequencer #(
  parameter int NUM_OUTPUTS    = 4,
  parameter int ASSERT_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n_in,
  input  logic                   sw_rst_req,
  output logic                   sw_rst_ack,
  output logic [NUM_OUTPUTS-1:0] rst_n_out,
  output logic                   rst_done,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NUM_OUTPUTS + 1);
  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST  = CNT_WIDTH'(ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGGER_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_ALL      = IDX_W'(NUM_OUTPUTS);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_OUTPUTS-1:0] rst_n_out_q, rst_n_out_d;
  logic                   ack_q, ack_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_n_out_d = rst_n_out_q;
    ack_d       = ack_q & sw_rst_req;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == ASSERT_LAST) begin
          rst_n_out_d[0] = 1'b1;
          cnt_d          = '0;
          idx_d          = IDX_W'(1);
          state_d        = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RELEASE: begin
        if (idx_q == IDX_ALL) begin
          state_d = S_RUN;
        end else if (cnt_q == STAGGER_LAST) begin
          for (int k = 0; k < NUM_OUTPUTS; k++) begin
            if (idx_q == IDX_W'(k)) rst_n_out_d[k] = 1'b1;
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_RUN:   ;
      default: state_d = S_HOLD;
    endcase

    // A pending request is taken on the very edge the sequence would reach RUN.
    if (state_d == S_RUN && sw_rst_req && !ack_q) begin
      state_d     = S_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      rst_n_out_d = '0;
      ack_d       = 1'b1;
    end

    done_d = (state_d == S_RUN);
    busy_d = (state_d != S_RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_n_out_q <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_n_out_q <= rst_n_out_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign sw_rst_ack = ack_q;
  assign rst_n_out  = rst_n_out_q;
  assign rst_done   = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: default instance plus a 1/1/1 instance, both checked
// every cycle against an elapsed-time schedule model, with directed and random stimulus.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       ack0, done0, busy0;
  logic [3:0] out0;
  logic       ack1, done1, busy1;
  logic [0:0] out1;

  int checks = 0;
  int errors = 0;

  // Schedule model state: edge count since reset release, start edge of the current sequence, ack.
  int   edge_cnt = 0;
  int   s0 = 0, s1 = 0;
  logic mack0 = 1'b0, mack1 = 1'b0;

  localparam int TDONE0 = 16 + 3 * 4 + 1;
  localparam int TDONE1 = 1 + 0 * 1 + 1;

  always #5 clk = ~clk;

  reset_sequencer dut0 (
    .clk(clk), .rst_n_in(rst_n_in), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack0),
    .rst_n_out(out0), .rst_done(done0), .busy(busy0)
  );

  reset_sequencer #(
    .NUM_OUTPUTS(1), .ASSERT_CYCLES(1), .STAGGER_CYCLES(1), .CNT_WIDTH(8)
  ) dut1 (
    .clk(clk), .rst_n_in(rst_n_in), .sw_rst_req(sw_rst_req), .sw_rst_ack(ack1),
    .rst_n_out(out1), .rst_done(done1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  function automatic logic [3:0] exp_bits(input int e, input int n, input int a, input int st);
    logic [3:0] b = '0;
    for (int k = 0; k < n; k++) if (e >= a + k * st) b[k] = 1'b1;
    return b;
  endfunction

  function automatic void model_step(input int ec, input logic req, input int tdone,
                                     inout int s, inout logic ack);
    if ((ec - s) >= tdone && req && !ack) begin
      s   = ec;
      ack = 1'b1;
    end else begin
      ack = ack & req;
    end
  endfunction

  // Model update at each edge, comparison 1 time unit later.
  always @(posedge clk) begin
    if (!rst_n_in) begin
      edge_cnt = 0; s0 = 0; s1 = 0; mack0 = 1'b0; mack1 = 1'b0;
    end else begin
      edge_cnt++;
      model_step(edge_cnt, sw_rst_req, TDONE0, s0, mack0);
      model_step(edge_cnt, sw_rst_req, TDONE1, s1, mack1);
    end
    #1;
    check("d0_rst_n_out", {28'd0, out0}, {28'd0, exp_bits(edge_cnt - s0, 4, 16, 4)});
    check("d0_done", {31'd0, done0}, {31'd0, (edge_cnt - s0) >= TDONE0});
    check("d0_busy", {31'd0, busy0}, {31'd0, (edge_cnt - s0) < TDONE0});
    check("d0_ack", {31'd0, ack0}, {31'd0, mack0});
    check("d1_rst_n_out", {31'd0, out1}, {28'd0, exp_bits(edge_cnt - s1, 1, 1, 1)});
    check("d1_done", {31'd0, done1}, {31'd0, (edge_cnt - s1) >= TDONE1});
    check("d1_busy", {31'd0, busy1}, {31'd0, (edge_cnt - s1) < TDONE1});
    check("d1_ack", {31'd0, ack1}, {31'd0, mack1});
  end

  // Both helpers assume the caller sits on a falling edge.
  task automatic upto_edge(input int n);
    int guard = 0;
    while (edge_cnt < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (edge_cnt < n) begin
      $display("FAIL timeout: edge %0d never reached, at %0d", n, edge_cnt);
      errors++;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n_in = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n_in = 1'b1;
  endtask

  initial begin
    // Power-on with a request raised at edge 10 while busy; held through completion.
    sw_rst_req = 1'b0;
    rst_n_in   = 1'b0;
    repeat (5) @(negedge clk);
    rst_n_in = 1'b1;
    upto_edge(1);
    check("p1_d1_bit0_e1", {31'd0, out1}, 32'd1);
    check("p1_d1_done_e1", {31'd0, done1}, 32'd0);
    upto_edge(2);
    check("p1_d1_done_e2", {31'd0, done1}, 32'd1);
    upto_edge(9);
    sw_rst_req = 1'b1;
    upto_edge(15);
    check("p1_out_e15", {28'd0, out0}, 32'h0);
    check("p1_ack_busy_e15", {31'd0, ack0}, 32'd0);
    upto_edge(16);
    check("p1_out_e16", {28'd0, out0}, 32'h1);
    upto_edge(20);
    check("p1_out_e20", {28'd0, out0}, 32'h3);
    upto_edge(24);
    check("p1_out_e24", {28'd0, out0}, 32'h7);
    upto_edge(28);
    check("p1_out_e28", {28'd0, out0}, 32'hF);
    check("p1_done_e28", {31'd0, done0}, 32'd0);
    upto_edge(29);
    check("busyreq_out_e29", {28'd0, out0}, 32'h0);
    check("busyreq_ack_e29", {31'd0, ack0}, 32'd1);
    check("busyreq_done_e29", {31'd0, done0}, 32'd0);
    upto_edge(58);
    check("held_done_e58", {31'd0, done0}, 32'd1);
    check("held_ack_e58", {31'd0, ack0}, 32'd1);
    upto_edge(85);
    check("held_no_retrigger", {31'd0, done0}, 32'd1);
    check("held_out_e85", {28'd0, out0}, 32'hF);
    upto_edge(89);
    sw_rst_req = 1'b0;
    upto_edge(90);
    check("held_ack_drop", {31'd0, ack0}, 32'd0);
    upto_edge(94);
    sw_rst_req = 1'b1;
    upto_edge(95);
    check("rereq_accept_ack", {31'd0, ack0}, 32'd1);
    check("rereq_accept_done", {31'd0, done0}, 32'd0);
    upto_edge(99);
    sw_rst_req = 1'b0;

    // Software reset at edge 40 on a clean power-on, dropped at edge 45.
    do_reset(3);
    upto_edge(39);
    sw_rst_req = 1'b1;
    upto_edge(40);
    check("sw_ack_e40", {31'd0, ack0}, 32'd1);
    check("sw_out_e40", {28'd0, out0}, 32'h0);
    check("sw_done_e40", {31'd0, done0}, 32'd0);
    upto_edge(44);
    sw_rst_req = 1'b0;
    check("sw_ack_e44", {31'd0, ack0}, 32'd1);
    upto_edge(45);
    check("sw_ack_e45", {31'd0, ack0}, 32'd0);
    upto_edge(55);
    check("sw_out_e55", {28'd0, out0}, 32'h0);
    upto_edge(56);
    check("sw_out_e56", {28'd0, out0}, 32'h1);
    upto_edge(60);
    check("sw_out_e60", {28'd0, out0}, 32'h3);
    upto_edge(64);
    check("sw_out_e64", {28'd0, out0}, 32'h7);
    upto_edge(68);
    check("sw_out_e68", {28'd0, out0}, 32'hF);
    check("sw_done_e68", {31'd0, done0}, 32'd0);
    upto_edge(69);
    check("sw_done_e69", {31'd0, done0}, 32'd1);
    check("sw_busy_e69", {31'd0, busy0}, 32'd0);

    // Mid-sequence abort between edges 21 and 22.
    do_reset(3);
    upto_edge(21);
    check("abort_pre_out", {28'd0, out0}, 32'h3);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("abort_out_async", {28'd0, out0}, 32'h0);
    check("abort_ack_async", {31'd0, ack0}, 32'd0);
    check("abort_busy_async", {31'd0, busy0}, 32'd1);
    check("abort_done_async", {31'd0, done0}, 32'd0);
    check("abort_d1_out_async", {31'd0, out1}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n_in = 1'b1;
    upto_edge(15);
    check("abort_out_e15", {28'd0, out0}, 32'h0);
    upto_edge(16);
    check("abort_out_e16", {28'd0, out0}, 32'h1);
    upto_edge(29);
    check("abort_done_e29", {31'd0, done0}, 32'd1);

    // Random request toggling with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 4));
        rst_n_in = 1'b0;
        #1;
        check("rand_async_out", {28'd0, out0}, 32'h0);
        check("rand_async_ack", {31'd0, ack0}, 32'd0);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_n_in = 1'b1;
      end else if ($urandom_range(0, 24) == 0) begin
        sw_rst_req = ~sw_rst_req;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
